// File: rtl/uart_rx_param.sv
// Oversampled UART receiver: start/DATA_W data/stop framing, valid/ready output register, error pulses.
// Define UART_RX_PARITY_EN to compile in the parity bit and its check (sense set by PARITY_ODD).
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx_serial,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun,
    output logic              busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_chk_clks
        $error("CLKS_PER_BIT must be even and >= 4");
    end
    if (DATA_W < 5 || DATA_W > 9) begin : g_chk_width
        $error("DATA_W must be in 5..9");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_chk_parity
        $error("PARITY_ODD must be 0 or 1");
    end

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam logic ODD_BIT = (PARITY_ODD != 0);
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t            state, state_nx;
    logic              rx_m, rx_s, rx_p;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [BW-1:0]     bit_cnt, bit_cnt_nx;
    logic [DATA_W-1:0] shreg, shreg_nx;
    logic              frame_done, stop_bad, par_fail, deliver;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_p <= 1'b1;
        end else begin
            rx_m <= rx_serial;
            rx_s <= rx_m;
            rx_p <= rx_s;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad, par_bad_nx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            par_bad    <= par_bad_nx;
            parity_err <= frame_done && par_bad;
        end
    end

    assign par_fail = par_bad;
`else
    assign par_fail   = 1'b0;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_cnt <= bit_cnt_nx;
            shreg   <= shreg_nx;
        end
    end

    // Counter restarts at the start-bit centre, so every later sample lands on count CNT_LAST.
    always_comb begin
        state_nx   = state;
        cnt_nx     = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        bit_cnt_nx = bit_cnt;
        shreg_nx   = shreg;
`ifdef UART_RX_PARITY_EN
        par_bad_nx = par_bad;
`endif
        frame_done = 1'b0;
        stop_bad   = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (rx_p && !rx_s) state_nx = START;
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_nx     = '0;
                    bit_cnt_nx = '0;
                    state_nx   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    shreg_nx   = {rx_s, shreg[DATA_W-1:1]};
                    bit_cnt_nx = bit_cnt + 1'b1;
                    if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == CNT_LAST) begin
                    par_bad_nx = rx_s ^ (^shreg) ^ ODD_BIT;
                    state_nx   = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == CNT_LAST) begin
                    frame_done = 1'b1;
                    stop_bad   = !rx_s;
                    state_nx   = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign deliver = frame_done && !stop_bad && !par_fail;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= frame_done && stop_bad;
            overrun   <= 1'b0;
            if (deliver) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: frame-level model predicts each frame's outcome and cycle.
module tb_uart_rx_param;
    localparam int C   = 16;
    localparam int DW  = 8;
    localparam int POD = 0;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    // pin fall -> outcome visible: 2 sync + half bit + remaining bits + 1 register
    localparam int EV_LAT = 2 + C / 2 + (DW + 1 + PB) * C + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          rx_serial = 1'b1;
    logic          rx_ready = 1'b1;
    logic [DW-1:0] rx_data;
    logic          rx_valid, frame_err, parity_err, overrun, busy;

    uart_rx_param #(.CLKS_PER_BIT(C), .DATA_W(DW), .PARITY_ODD(POD)) dut (
        .clk(clk), .reset_n(reset_n), .rx_serial(rx_serial),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // code bits: {new word, frame_err, parity_err, overrun}
    typedef struct {
        logic [3:0]    code;
        logic [DW-1:0] data;
        int unsigned   at;
    } ev_t;

    ev_t           sb[$];
    int            n_vec = 0;
    int            n_err = 0;
    bit            slot_full = 1'b0;
    logic [DW-1:0] slot_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic hold(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input bit stop_bit, input bit flip,
                              input int unsigned stop_len);
        ev_t e;
        bit  par_ok;
        @(posedge clk);
        #1;
        par_ok = !(flip && PB == 1);
        e.at   = cyc + EV_LAT;
        e.data = d;
        if (!stop_bit || !par_ok) begin
            e.code = {1'b0, !stop_bit, !par_ok, 1'b0};
        end else if (!rx_ready && slot_full) begin
            e.code = 4'b0001;
            e.data = slot_data;
        end else begin
            e.code = 4'b1000;
            if (!rx_ready) begin
                slot_full = 1'b1;
                slot_data = d;
            end
        end
        sb.push_back(e);
        rx_serial = 1'b0;
        hold(C);
        for (int i = 0; i < DW; i++) begin
            rx_serial = d[i];
            hold(C);
        end
        if (PB == 1) begin
            rx_serial = (^d) ^ (POD != 0) ^ flip;
            hold(C);
        end
        rx_serial = stop_bit;
        hold(stop_len);
        rx_serial = 1'b1;
    endtask

    task automatic set_ready(input logic r);
        rx_ready = r;
        if (r) slot_full = 1'b0;
    endtask

    initial begin : monitor
        logic       pv, pa, nw;
        logic [3:0] code;
        ev_t        e;
        pv = 1'b0;
        pa = 1'b0;
        forever begin
            @(negedge clk);
            nw   = rx_valid && (!pv || pa);
            code = {nw, frame_err, parity_err, overrun};
            if (reset_n && code != 4'b0000) begin
                if (sb.size() == 0) begin
                    check("unexpected_event", {28'b0, code}, 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("event_kind", {28'b0, code}, {28'b0, e.code});
                    check("event_cycle", cyc, e.at);
                    if (nw || overrun) check("rx_data", {24'b0, rx_data}, {24'b0, e.data});
                end
            end
            pv = rx_valid;
            pa = rx_valid && rx_ready;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached with %0d events pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int unsigned f;
        logic [DW-1:0] d;
        bit sb_ok, fl;
        hold(3);
        check("reset_rx_valid", {31'b0, rx_valid}, 32'h0);
        check("reset_rx_data", {24'b0, rx_data}, 32'h0);
        check("reset_frame_err", {31'b0, frame_err}, 32'h0);
        check("reset_parity_err", {31'b0, parity_err}, 32'h0);
        check("reset_overrun", {31'b0, overrun}, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        reset_n = 1'b1;
        hold(4);
        check("idle_busy", {31'b0, busy}, 32'h0);

        send_frame(8'hA5, 1'b1, 1'b0, C);
        check("valid_is_pulse", {31'b0, rx_valid}, 32'h0);

        // 4-cycle low glitch: START entered, abandoned at the half-bit sample
        @(posedge clk);
        #1;
        f = cyc;
        rx_serial = 1'b0;
        hold(3);
        check("glitch_busy_t0p1", {31'b0, busy}, 32'h1);
        hold(1);
        rx_serial = 1'b1;
        hold(6);
        check("glitch_busy_t0p8", {31'b0, busy}, 32'h1);
        hold(1);
        check("glitch_busy_t0p9", {31'b0, busy}, 32'h0);
        check("glitch_cycle", cyc, f + 11);
        hold(C);

        send_frame(8'h3C, 1'b0, 1'b0, C);
        send_frame(8'h11, 1'b1, 1'b0, C);

        // next start edge right after the stop-bit centre
        send_frame(8'h96, 1'b1, 1'b0, C / 2);
        send_frame(8'h69, 1'b1, 1'b0, C);

        set_ready(1'b0);
        send_frame(8'h01, 1'b1, 1'b0, C);
        send_frame(8'h02, 1'b1, 1'b0, C);
        hold(C);
        check("overrun_hold_valid", {31'b0, rx_valid}, 32'h1);
        check("overrun_hold_data", {24'b0, rx_data}, 32'h01);
        set_ready(1'b1);
        hold(2);
        check("drain_valid", {31'b0, rx_valid}, 32'h0);

        if (PB == 1) begin
            send_frame(8'h07, 1'b1, 1'b0, C);
            send_frame(8'h07, 1'b1, 1'b1, C);
            send_frame(8'hC3, 1'b0, 1'b1, C);
            send_frame(8'h44, 1'b1, 1'b0, C);
        end

        // hold a word, then reset in the middle of data bit 4 of 0xFF
        set_ready(1'b0);
        send_frame(8'h33, 1'b1, 1'b0, C);
        hold(C);
        @(posedge clk);
        #1;
        rx_serial = 1'b0;
        hold(C);
        for (int i = 0; i < 4; i++) begin
            rx_serial = 1'b1;
            hold(C);
        end
        hold(C / 2);
        reset_n = 1'b0;
        #1;
        check("midreset_valid", {31'b0, rx_valid}, 32'h0);
        check("midreset_data", {24'b0, rx_data}, 32'h0);
        check("midreset_busy", {31'b0, busy}, 32'h0);
        sb_ok = (sb.size() == 0);
        check("midreset_sb_empty", {31'b0, sb_ok}, 32'h1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        set_ready(1'b1);
        hold(5 * C);
        check("post_reset_busy", {31'b0, busy}, 32'h0);
        send_frame(8'h5A, 1'b1, 1'b0, C);

        for (int n = 0; n < 24; n++) begin
            hold(C);
            set_ready(logic'($urandom_range(0, 2) != 0));
            d  = DW'($urandom);
            fl = (PB == 1) && ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) send_frame(d, 1'b0, fl, C);
            else send_frame(d, 1'b1, fl, $urandom_range(C / 2, 2 * C));
        end

        hold(2 * C);
        sb_ok = (sb.size() == 0);
        check("scoreboard_drained", {31'b0, sb_ok}, 32'h1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised asynchronous serial receiver for the IEEE serial link. It recovers frames of 1 start bit, DATA_W data bits (LSB first), an optional parity bit and 1 stop bit from an oversampled line. It presents each received word on a valid/ready output register and flags framing, parity and overrun errors. It sits between the external RX pin and the downstream packet logic, and replaces the fixed 8-bit, one-clock-per-bit receiver.

## Interface
- CLKS_PER_BIT, 16, clk cycles per serial bit; even, ≥ 4
- DATA_W, 8, data bits per frame; 5..9
- PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd
- Reset: reset_n, asynchronous, active-low. Clock: clk.
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- rx_serial  input  1  raw serial line, idle high, asynchronous to clk
- rx_data  output  DATA_W  received word; valid while rx_valid=1
- rx_valid  output  1  word available; held until accepted
- rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- parity_err  output  1  one-cycle pulse: parity mismatch
- overrun  output  1  one-cycle pulse: frame completed while rx_valid && !rx_ready
- busy  output  1  FSM not in IDLE

## Operation
- rx_serial passes through a 2-flop synchronizer (reset value 1). All logic uses the synchronized value rx_s and its previous value rx_p.
- FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- IDLE: a falling edge (rx_p=1, rx_s=0) → START. The baud counter clears. A line held low does not retrigger.
- START: at count CLKS_PER_BIT/2-1, sample rx_s. If it is 1 (glitch) → IDLE. If it is 0 → DATA, and the counter reloads so that later samples fall at bit centres.
- DATA: sample every CLKS_PER_BIT cycles and shift in LSB first. After DATA_W samples → PARITY, or → STOP when parity is compiled out.
- PARITY: sample once and compare against the XOR of the data bits, XORed with PARITY_ODD.
- STOP: sample once, then → IDLE on the next cycle.
  - If the stop sample is 1 and parity is OK, the word is delivered.
  - If the stop sample is 0, frame_err pulses and the word is discarded.
  - If the parity is wrong, parity_err pulses and the word is discarded.
  - If both conditions hold, both pulses fire.
- Output register behaviour:
  - Delivery with rx_valid=0, or with rx_valid && rx_ready in the same cycle: load rx_data, rx_valid=1, no overrun.
  - Delivery with rx_valid && !rx_ready: old word kept, new word dropped, overrun pulses.
  - Accept without delivery: rx_valid → 0 on the next edge. rx_data holds its last value.
- Baud counter width: $clog2(CLKS_PER_BIT). Bit counter width: $clog2(DATA_W+1). The counter wraps at CLKS_PER_BIT-1 to 0.

## Timing
- Reset values:
  - rx_data = 0, rx_valid = 0, frame_err = 0, parity_err = 0, overrun = 0, busy = 0.
  - FSM = IDLE, synchronizer flops = 1.
- t0 = first cycle rx_s=0, which is 2 clk after the pin falls. busy=1 from t0+1.
- Start sample at t0+CLKS_PER_BIT/2. Data bit k (k=0..DATA_W-1) is sampled at t0+CLKS_PER_BIT/2+(k+1)·CLKS_PER_BIT. Parity and stop follow at the same pitch.
- rx_valid, frame_err, parity_err and overrun all assert on the cycle after the stop sample.
- Default configuration, parity out: stop sample at t0+152, rx_valid high at t0+153.
- A back-to-back frame whose start edge arrives right after the stop bit centre is received without loss.
- reset_n asserted mid-frame: immediate return to reset values, and the partial word is discarded. After release, a new frame needs a fresh falling edge.

## Configuration
- UART_RX_PARITY_EN defined:
  - The PARITY state and the parity check are present.
  - The frame is 1+DATA_W+1+1 bits.
  - PARITY_ODD selects the sense.
- UART_RX_PARITY_EN undefined:
  - No PARITY state; the frame is 1+DATA_W+1 bits.
  - parity_err is tied to 0 and PARITY_ODD is ignored.

## Test plan
- Defaults, rx_ready=1, send 0xA5 → rx_data=0xA5, rx_valid is a 1-cycle pulse at t0+153, no error flags.
- Low glitch of 4 cycles on an idle line → no state change beyond START, busy drops by t0+9, rx_valid stays 0.
- Send 0x3C with the stop bit forced low → frame_err pulse at t0+153, rx_valid=0, and a following frame 0x11 is received correctly.
- rx_ready=0, send 0x01 then 0x02 → rx_valid holds with 0x01, overrun pulses at the end of the second frame, and rx_data remains 0x01.
- UART_RX_PARITY_EN, PARITY_ODD=0:
  - Send 0x07 with parity bit 1 → accepted.
  - Send 0x07 with parity bit 0 → parity_err pulse, no rx_valid.
- Assert reset_n for 1 cycle at data bit 4 of 0xFF → outputs go to reset values, and the next frame 0x5A is received correctly.
